// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR coefficient bank controller.
package fir_pkg;

    localparam int NTAPS = 65;
    localparam int CW    = 18;
    localparam int AW    = 7;

    localparam logic [AW-1:0] TAP_LAST  = AW'(NTAPS - 1);
    localparam logic [AW-1:0] TAP_COUNT = AW'(NTAPS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/coef_bank_ram.sv
// Two-bank tap memory: one synchronous write port into the shadow bank and
// one registered read port from the active bank.
module coef_bank_ram
    import fir_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    input  logic          rzero,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem_r [0:1][0:NTAPS-1];

    // Tap storage, indexed {bank, tap}; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[wbank][waddr] <= wdata;
        end
    end

    // Read register; rzero covers out-of-range taps and the pre-activation state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= {CW{1'b0}};
        end else if (rzero) begin
            rdata <= {CW{1'b0}};
        end else begin
            rdata <= mem_r[rbank][raddr];
        end
    end

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered coefficient store: host loads the shadow bank, the filter
// reads the active bank, and the banks swap only on a frame boundary.
module fir_coef_bank_ctrl
    import fir_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_ready,
    output logic          cfg_done,
    output logic          cfg_error,
    input  logic          frame_start,
    input  logic [AW-1:0] coefaddress,
    output logic [CW-1:0] coefdata,
    output logic          coef_valid,
    output logic          active_bank,
    output logic          swap_pending
);

    state_t        state_r;
    logic [AW-1:0] wr_ptr_r;
    logic          wr_en_s;
    logic          rzero_s;

    // Tap write qualifier (a restart wins over a same-cycle tap) and read blanking.
    always_comb begin
        wr_en_s = 1'b0;
        rzero_s = 1'b1;
        if ((state_r == ST_LOAD) && cfg_valid && cfg_ready && !cfg_start) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        if (coef_valid && (coefaddress < TAP_COUNT)) begin
            rzero_s = 1'b0;
        end else begin
            rzero_s = 1'b1;
        end
    end

    // Load sequencer, bank select and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            cfg_ready    <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            coef_valid   <= 1'b0;
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_r   <= ST_LOAD;
                        wr_ptr_r  <= {AW{1'b0}};
                        cfg_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cfg_start) begin
                        wr_ptr_r  <= {AW{1'b0}};
                        cfg_error <= 1'b1;
                    end else if (wr_en_s) begin
                        if (wr_ptr_r == TAP_LAST) begin
                            state_r      <= ST_WAIT_SWAP;
                            wr_ptr_r     <= {AW{1'b0}};
                            cfg_ready    <= 1'b0;
                            swap_pending <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + 7'd1;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    if (cfg_start) begin
                        cfg_error <= 1'b1;
                    end
                    if (frame_start) begin
                        state_r      <= ST_IDLE;
                        active_bank  <= ~active_bank;
                        coef_valid   <= 1'b1;
                        swap_pending <= 1'b0;
                        cfg_done     <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    wr_ptr_r     <= {AW{1'b0}};
                    cfg_ready    <= 1'b0;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

    coef_bank_ram u_ram (
        .clock (clock),
        .reset (reset),
        .we    (wr_en_s),
        .wbank (~active_bank),
        .waddr (wr_ptr_r),
        .wdata (cfg_data),
        .rbank (active_bank),
        .raddr (coefaddress),
        .rzero (rzero_s),
        .rdata (coefdata)
    );

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed self-checking bench for fir_coef_bank_ctrl.
module tb_fir_coef_bank_ctrl;
    import fir_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_error;
    logic          frame_start = 1'b0;
    logic [AW-1:0] coefaddress = '0;
    logic [CW-1:0] coefdata;
    logic          coef_valid;
    logic          active_bank;
    logic          swap_pending;

    int checks = 0;
    int failures = 0;
    logic exp_bank = 1'b0;

    fir_coef_bank_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .frame_start  (frame_start),
        .coefaddress  (coefaddress),
        .coefdata     (coefdata),
        .coef_valid   (coef_valid),
        .active_bank  (active_bank),
        .swap_pending (swap_pending)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic load_taps(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = CW'(base + k);
            cyc();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        check_eq("ready_in_load", 32'(cfg_ready), 32'd1);
    endtask

    task automatic activate();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        exp_bank = ~exp_bank;
        check_eq("done_pulse", 32'(cfg_done), 32'd1);
        check_eq("bank_after_swap", 32'(active_bank), 32'(exp_bank));
        check_eq("valid_after_swap", 32'(coef_valid), 32'd1);
        check_eq("pending_cleared", 32'(swap_pending), 32'd0);
        cyc();
        check_eq("done_one_cycle", 32'(cfg_done), 32'd0);
    endtask

    task automatic read_tap(input string tag, input int addr, input int exp);
        coefaddress = AW'(addr);
        cyc();
        check_eq(tag, 32'(coefdata), 32'(exp));
    endtask

    initial begin
        // 1: reset state and blank reads before any activation
        #2;
        check_eq("rst_ready", 32'(cfg_ready), 32'd0);
        check_eq("rst_valid", 32'(coef_valid), 32'd0);
        check_eq("rst_coefdata", 32'(coefdata), 32'd0);
        check_eq("rst_bank", 32'(active_bank), 32'd0);
        cyc();
        reset = 1'b0;
        for (int a = 0; a < NTAPS; a++) begin
            coefaddress = AW'(a);
            cyc();
            check_eq("pre_activation_read", 32'(coefdata), 32'd0);
            check_eq("pre_activation_valid", 32'(coef_valid), 32'd0);
        end
        check_eq("idle_ready", 32'(cfg_ready), 32'd0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        check_eq("idle_frame_no_swap", 32'(active_bank), 32'd0);
        check_eq("idle_frame_no_done", 32'(cfg_done), 32'd0);

        // 2: taps 1..65 into bank 1
        start_load();
        load_taps(1, NTAPS);
        check_eq("pending_after_load", 32'(swap_pending), 32'd1);
        check_eq("ready_in_wait", 32'(cfg_ready), 32'd0);
        activate();
        read_tap("read_addr10", 10, 11);

        // 3: set A active, set B shadowed until frame boundary
        start_load();
        load_taps(0, NTAPS);
        activate();
        read_tap("setA_addr7", 7, 7);
        start_load();
        load_taps(100, NTAPS);
        check_eq("setB_pending", 32'(swap_pending), 32'd1);
        read_tap("setA_still_read", 7, 7);
        coefaddress = AW'(20);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        exp_bank = ~exp_bank;
        check_eq("swap_cycle_old_bank", 32'(coefdata), 32'd20);
        check_eq("swap_cycle_done", 32'(cfg_done), 32'd1);
        cyc();
        check_eq("after_swap_new_bank", 32'(coefdata), 32'd120);
        check_eq("bank_setB", 32'(active_bank), 32'(exp_bank));

        // 4: restart after 30 taps; the colliding tap is dropped
        start_load();
        load_taps(500, 30);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = CW'(999);
        cyc();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check_eq("restart_error", 32'(cfg_error), 32'd1);
        cyc();
        check_eq("error_one_cycle", 32'(cfg_error), 32'd0);
        load_taps(200, NTAPS - 1);
        check_eq("no_pending_at_64", 32'(swap_pending), 32'd0);
        check_eq("still_loading", 32'(cfg_ready), 32'd1);
        load_taps(200 + NTAPS - 1, 1);
        check_eq("pending_at_65", 32'(swap_pending), 32'd1);
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        check_eq("wait_start_error", 32'(cfg_error), 32'd1);
        check_eq("wait_start_ignored", 32'(swap_pending), 32'd1);
        activate();
        read_tap("restart_tap0", 0, 200);
        read_tap("restart_tap29", 29, 229);

        // 5: last tap and out-of-range addresses
        read_tap("last_tap", 64, 264);
        read_tap("addr65_zero", 65, 0);
        read_tap("addr127_zero", 127, 0);

        // 6: asynchronous reset in the middle of a load
        coefaddress = AW'(5);
        start_load();
        load_taps(300, 20);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_rst_ready", 32'(cfg_ready), 32'd0);
        check_eq("async_rst_valid", 32'(coef_valid), 32'd0);
        check_eq("async_rst_bank", 32'(active_bank), 32'd0);
        check_eq("async_rst_coefdata", 32'(coefdata), 32'd0);
        check_eq("async_rst_pending", 32'(swap_pending), 32'd0);
        cyc();
        reset = 1'b0;
        read_tap("post_rst_read", 5, 0);
        check_eq("post_rst_valid", 32'(coef_valid), 32'd0);
        check_eq("post_rst_idle", 32'(cfg_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
